// File: rtl/biquad_coef_loader.sv
// biquad_coef_loader
//   Double-buffered coefficient store for a biquad filter. Writes fill a shadow
//   bank. A commit checks that bank, and the active outputs then take all five
//   coefficients together on the next sample_tick. Coefficients never change
//   in the middle of a sample.
//
// Optional feature macro: BIQUAD_COEF_STABILITY_CHECK_EN
//   defined   -> a commit is rejected unless a2 != -1.0 and |a1| < 1 - a2
//   undefined -> every commit is accepted and err_unstable stays 0
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   wr_valid/wr_ready     write handshake (see below)
//   wr_addr, wr_data      0=b0 1=b1 2=b2 3=a1 4=a2; 5..7 set err_addr
//   commit                request to publish the shadow bank
//   sample_tick           sample boundary strobe; publishes a pending bank
//   b0,b1,b2,a1,a2        active coefficients (signed, registered)
//   coef_update           one-cycle pulse when the active bank changes
//   pending               commit accepted, waiting for sample_tick
//   err_addr              sticky: write to an invalid address accepted
//   err_unstable          sticky: commit rejected by the stability check
//   state_dbg             controller state (IDLE=0, EVAL=1, PEND=2)
//
// Handshake: a write transfers on any rising edge where wr_valid && wr_ready.
// wr_ready is high only in IDLE. It is low in EVAL, the cycle after an
// accepted commit, and in PEND. The bank being checked or published therefore
// cannot change underneath the controller.
module biquad_coef_loader #(
  parameter int COEF_WIDTH         = 24,
  parameter int COEF_DECIMAL_WIDTH = 23,
  parameter logic [COEF_WIDTH-1:0] B0_INIT = '0,
  parameter logic [COEF_WIDTH-1:0] B1_INIT = '0,
  parameter logic [COEF_WIDTH-1:0] B2_INIT = '0,
  parameter logic [COEF_WIDTH-1:0] A1_INIT = '0,
  parameter logic [COEF_WIDTH-1:0] A2_INIT = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [2:0]                   wr_addr,
  input  logic [COEF_WIDTH-1:0]        wr_data,
  input  logic                         commit,
  input  logic                         sample_tick,
  output logic signed [COEF_WIDTH-1:0] b0,
  output logic signed [COEF_WIDTH-1:0] b1,
  output logic signed [COEF_WIDTH-1:0] b2,
  output logic signed [COEF_WIDTH-1:0] a1,
  output logic signed [COEF_WIDTH-1:0] a2,
  output logic                         coef_update,
  output logic                         pending,
  output logic                         err_addr,
  output logic                         err_unstable,
  output logic [1:0]                   state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,   // commit sampled last edge; checking the shadow bank
    ST_PEND = 2'd2    // bank accepted; waiting for sample_tick
  } state_t;

  // Bank index matches wr_addr: [0]=b0 [1]=b1 [2]=b2 [3]=a1 [4]=a2.
  localparam logic [4:0][COEF_WIDTH-1:0] INIT_BANK =
    {A2_INIT, A1_INIT, B2_INIT, B1_INIT, B0_INIT};

  // The fractional point must fall inside the word.
  if (COEF_DECIMAL_WIDTH < 0 || COEF_DECIMAL_WIDTH >= COEF_WIDTH) begin : g_bad_decimal_width
    $error("COEF_DECIMAL_WIDTH must be in [0, COEF_WIDTH-1]");
  end

  state_t                       state_q, state_d;
  logic [4:0][COEF_WIDTH-1:0]   shadow_q, shadow_d;
  logic [4:0][COEF_WIDTH-1:0]   active_q, active_d;
  logic                         coef_update_q, coef_update_d;
  logic                         err_addr_q, err_addr_d;
  logic                         err_unstable_q, err_unstable_d;
  logic                         eval_pass;

`ifdef BIQUAD_COEF_STABILITY_CHECK_EN
  // Two extra bits hold 1.0 (2^DEC), |a1| up to 2^(W-1), and 1 - a2 up to
  // 2^W without overflow.
  localparam int XW = COEF_WIDTH + 2;
  localparam logic signed [XW-1:0] ONE = XW'(1) << COEF_DECIMAL_WIDTH;
  localparam logic [COEF_WIDTH-1:0] COEF_MIN = {1'b1, {(COEF_WIDTH-1){1'b0}}};

  logic signed [XW-1:0] a1_x, a2_x, a1_abs, margin;

  always_comb begin
    a1_x      = XW'($signed(shadow_q[3]));
    a2_x      = XW'($signed(shadow_q[4]));
    a1_abs    = a1_x[XW-1] ? -a1_x : a1_x;
    margin    = ONE - a2_x;
    eval_pass = (shadow_q[4] != COEF_MIN) && (a1_abs < margin);
  end
`else
  assign eval_pass = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    coef_update_d  = 1'b0;
    err_addr_d     = err_addr_q;
    err_unstable_d = err_unstable_q;
    wr_ready       = (state_q == ST_IDLE);

    if (wr_valid && wr_ready) begin
      if (wr_addr <= 3'd4) begin
        shadow_d[wr_addr] = wr_data;
      end else begin
        err_addr_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (commit) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (eval_pass) begin
          state_d        = ST_PEND;
          err_addr_d     = 1'b0;
          err_unstable_d = 1'b0;
        end else begin
          state_d        = ST_IDLE;
          err_unstable_d = 1'b1;
        end
      end
      ST_PEND: begin
        if (sample_tick) begin
          active_d      = shadow_q;
          coef_update_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      shadow_q       <= INIT_BANK;
      active_q       <= INIT_BANK;
      coef_update_q  <= 1'b0;
      err_addr_q     <= 1'b0;
      err_unstable_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      coef_update_q  <= coef_update_d;
      err_addr_q     <= err_addr_d;
      err_unstable_q <= err_unstable_d;
    end
  end

  assign b0           = active_q[0];
  assign b1           = active_q[1];
  assign b2           = active_q[2];
  assign a1           = active_q[3];
  assign a2           = active_q[4];
  assign coef_update  = coef_update_q;
  assign pending      = (state_q == ST_PEND);
  assign err_addr     = err_addr_q;
  assign err_unstable = err_unstable_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Testbench for biquad_coef_loader. Directed scenarios, then a random phase.
// Each cycle is checked against a transaction-level model: shadow/active
// arrays, a pending flag and an "evaluate next cycle" flag. The stability rule
// is computed with plain 64-bit integer arithmetic.
module tb_biquad_coef_loader;
  localparam int W = 24;
  localparam int D = 23;
  localparam logic [W-1:0] B0I = 24'h0A0000;
  localparam logic [W-1:0] B1I = 24'h123456;
  localparam logic [W-1:0] B2I = 24'hFEDCBA;
  localparam logic [W-1:0] A1I = 24'hC00000;
  localparam logic [W-1:0] A2I = 24'h200000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, wr_valid, commit, sample_tick;
  logic [2:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_ready, coef_update, pending, err_addr, err_unstable;
  logic [W-1:0]  b0, b1, b2, a1, a2;
  logic [1:0]    state_dbg;

  biquad_coef_loader #(
    .COEF_WIDTH(W), .COEF_DECIMAL_WIDTH(D),
    .B0_INIT(B0I), .B1_INIT(B1I), .B2_INIT(B2I), .A1_INIT(A1I), .A2_INIT(A2I)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .sample_tick(sample_tick),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .coef_update(coef_update), .pending(pending), .err_addr(err_addr),
    .err_unstable(err_unstable), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] init_m[5], shadow_m[5], active_m[5];
  bit m_pending, m_eval, m_upd, m_err_addr, m_err_unst;
  logic [W-1:0] exp_q[$];

  function automatic bit stable_ok(input logic [W-1:0] ca1, input logic [W-1:0] ca2);
`ifdef BIQUAD_COEF_STABILITY_CHECK_EN
    longint sa1, sa2, abs1;
    sa1  = longint'($signed(ca1));
    sa2  = longint'($signed(ca2));
    abs1 = (sa1 < 0) ? -sa1 : sa1;
    return (sa2 != -(longint'(1) << (W - 1))) && (abs1 < ((longint'(1) << D) - sa2));
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [2:0] a,
                            input logic [W-1:0] d, input bit c, input bit t, input bit rdy);
    m_upd = 1'b0;
    exp_q.delete();
    if (r) begin
      for (int i = 0; i < 5; i++) begin
        shadow_m[i] = init_m[i];
        active_m[i] = init_m[i];
      end
      m_pending = 0; m_eval = 0; m_err_addr = 0; m_err_unst = 0;
    end else begin
      if (m_eval) begin
        m_eval = 1'b0;
        if (stable_ok(shadow_m[3], shadow_m[4])) begin
          m_pending = 1'b1; m_err_addr = 1'b0; m_err_unst = 1'b0;
        end else begin
          m_err_unst = 1'b1;
        end
      end else if (m_pending && t) begin
        active_m  = shadow_m;
        m_pending = 1'b0;
        m_upd     = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(shadow_m[i]);
      end
      if (v && rdy) begin
        if (a <= 3'd4) shadow_m[a] = d;
        else           m_err_addr  = 1'b1;
      end
      if (c && rdy) m_eval = 1'b1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("wr_ready",     wr_ready,     !(m_eval || m_pending));
    chk("pending",      pending,      m_pending);
    chk("coef_update",  coef_update,  m_upd);
    chk("err_addr",     err_addr,     m_err_addr);
    chk("err_unstable", err_unstable, m_err_unst);
    chk("b0", b0, active_m[0]);
    chk("b1", b1, active_m[1]);
    chk("b2", b2, active_m[2]);
    chk("a1", a1, active_m[3]);
    chk("a2", a2, active_m[4]);
    if (coef_update === 1'b1) begin
      chk("upd_snapshot_size", W'(exp_q.size()), W'(5));
      if (exp_q.size() == 5) begin
        chk("upd_b0", b0, exp_q[0]);
        chk("upd_b1", b1, exp_q[1]);
        chk("upd_b2", b2, exp_q[2]);
        chk("upd_a1", a1, exp_q[3]);
        chk("upd_a2", a2, exp_q[4]);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit r, input bit v, input logic [2:0] a,
                       input logic [W-1:0] d, input bit c, input bit t);
    bit rdy;
    @(negedge clk);
    reset = r; wr_valid = v; wr_addr = a; wr_data = d; commit = c; sample_tick = t;
    rdy = !(m_eval || m_pending);
    @(posedge clk);
    model_edge(r, v, a, d, c, t, rdy);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 3'd0, '0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    init_m[0] = B0I; init_m[1] = B1I; init_m[2] = B2I; init_m[3] = A1I; init_m[4] = A2I;
    m_pending = 0; m_eval = 0; m_upd = 0; m_err_addr = 0; m_err_unst = 0;
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; sample_tick = 1'b0;

    // Reset values.
    cycle(1, 0, 3'd0, '0, 0, 0);
    idle(1);

    // Write b0 and a1 (commit alongside the a1 write), tick three cycles later.
    cycle(0, 1, 3'd0, 24'h200000, 0, 0);
    cycle(0, 1, 3'd3, 24'h400000, 1, 0);
    idle(2);
    cycle(0, 0, 3'd0, '0, 0, 1);
    idle(1);

    // Commit together with a tick, tick at N+1, then tick at N+2.
    cycle(0, 1, 3'd1, W'($urandom), 0, 0);
    cycle(0, 0, 3'd0, '0, 1, 1);
    cycle(0, 0, 3'd0, '0, 0, 1);
    cycle(0, 0, 3'd0, '0, 0, 1);
    idle(1);

    // Invalid address, then an accepted commit clears err_addr.
    cycle(0, 1, 3'd6, W'($urandom), 0, 0);
    idle(1);
    cycle(0, 0, 3'd0, '0, 1, 0);
    idle(2);
    cycle(0, 0, 3'd0, '0, 0, 1);

    // Unstable bank: rejected when the check is built in, accepted otherwise.
    cycle(0, 1, 3'd3, 24'h7FFFFF, 0, 0);
    cycle(0, 1, 3'd4, 24'h400000, 0, 0);
    cycle(0, 0, 3'd0, '0, 1, 0);
    idle(2);
    cycle(0, 0, 3'd0, '0, 0, 1);
    cycle(0, 1, 3'd3, 24'h000000, 0, 0);
    cycle(0, 0, 3'd0, '0, 1, 0);
    idle(2);
    cycle(0, 0, 3'd0, '0, 0, 1);
    // a2 = -1.0 boundary.
    cycle(0, 1, 3'd4, 24'h800000, 1, 0);
    idle(2);
    cycle(0, 0, 3'd0, '0, 0, 1);
    cycle(0, 1, 3'd4, 24'h000000, 0, 0);

    // Reset while pending cancels the commit.
    cycle(0, 1, 3'd2, W'($urandom), 1, 0);
    idle(2);
    cycle(1, 0, 3'd0, '0, 0, 1);
    cycle(0, 0, 3'd0, '0, 0, 1);
    idle(1);

    // Random phase.
    for (int n = 0; n < 600; n++) begin
      bit r, v, c, t;
      logic [2:0] a;
      logic [W-1:0] d;
      r = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 1) == 1);
      a = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 24'h1FFFFF)) : W'($urandom);
      c = ($urandom_range(0, 4) == 0);
      t = ($urandom_range(0, 2) == 0);
      cycle(r, v, a, d, c, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
